// File: rtl/compare_digit_driver.sv
// compare_digit_driver: streams two N-bit operands MSB-first as 2-bit digits into a serial comparator and returns its result
module compare_digit_driver #(
  parameter int N  = 16384,
  parameter int CC = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic         busy,
  output logic         cmp_rst,
  output logic [1:0]   x,
  output logic [1:0]   y,
  output logic         dvalid,
  input  logic         g_in,
  input  logic         e_in,
  output logic         done,
  output logic         gt,
  output logic         eq
);
  localparam int CW = CC > 1 ? $clog2(CC) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
  state_t state, state_n;
  logic [N-1:0] xs, ys;
  logic [CW-1:0] cnt;
  if (N % 2 != 0 || CC != N / 2) begin : g_bad_params
    $error("compare_digit_driver: N must be even and CC must equal N/2");
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? SHIFT : IDLE;
    else if (state == SHIFT) state_n = cnt == CW'(CC - 1) ? CAPTURE : SHIFT;
    else state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xs    <= '0;
      ys    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == CAPTURE;
      if (state == IDLE && start) begin
        xs  <= x_in;
        ys  <= y_in;
        cnt <= '0;
      end else if (state == SHIFT) begin
        xs  <= {xs[N-3:0], 2'b00};
        ys  <= {ys[N-3:0], 2'b00};
        cnt <= cnt + CW'(1);
      end
      if (state == CAPTURE) begin
        gt <= g_in;
        eq <= e_in;
      end
    end
  end
  // every comparator-facing output decodes from registered state only
  assign busy    = state != IDLE;
  assign cmp_rst = state == IDLE;
  assign dvalid  = state == SHIFT;
  assign x       = dvalid ? xs[N-1:N-2] : 2'b00;
  assign y       = dvalid ? ys[N-1:N-2] : 2'b00;
endmodule

// File: tb/tb_compare_digit_driver.sv
// tb_compare_digit_driver: table-driven check of the digit driver wired to a serial comparator model
module tb_compare_digit_driver;
  localparam int N = 8;
  localparam int CC = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] x_in = '0, y_in = '0;
  logic busy, cmp_rst, dvalid, done, gt, eq;
  logic [1:0] x, y;
  logic g_m, e_m;
  int n_chk = 0, n_fail = 0;
  logic prev_gt = 1'b0, prev_eq = 1'b0;

  compare_digit_driver #(.N(N), .CC(CC)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .cmp_rst(cmp_rst), .x(x), .y(y), .dvalid(dvalid),
    .g_in(g_m), .e_in(e_m), .done(done), .gt(gt), .eq(eq)
  );

  always #5 clk = ~clk;

  // serial 2-bit MSB-first comparator: first unequal digit decides
  always @(posedge clk) begin
    if (cmp_rst) begin
      g_m <= 1'b0;
      e_m <= 1'b1;
    end else if (dvalid && e_m && x != y) begin
      g_m <= x > y;
      e_m <= 1'b0;
    end
  end

  typedef struct {
    logic [N-1:0] xv;
    logic [N-1:0] yv;
    logic         gt;
    logic         eq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drives start before the next edge, then checks every cycle through the done cycle;
  // returns at the negedge of the done cycle
  task automatic run_op(input vec_t v, input bit poke);
    start = 1'b1;
    x_in = v.xv;
    y_in = v.yv;
    @(posedge clk);
    #1 start = 1'b0;
    x_in = ~v.xv;
    y_in = v.yv ^ 8'h5C;
    for (int i = 0; i < CC; i++) begin
      @(negedge clk);
      chk($sformatf("x_digit%0d", i), 32'(x), 32'(v.xv[N-1-2*i -: 2]));
      chk($sformatf("y_digit%0d", i), 32'(y), 32'(v.yv[N-1-2*i -: 2]));
      chk("shift_ctl", {dvalid, busy, cmp_rst, done}, 4'b1100);
      if (poke && i == 1) begin
        start = 1'b1;
        x_in = 8'h00;
        y_in = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    @(negedge clk);
    chk("capture_ctl", {dvalid, busy, cmp_rst, done, x, y}, 8'b01000000);
    chk("held_result", {gt, eq}, {prev_gt, prev_eq});
    @(negedge clk);
    chk("done_ctl", {dvalid, busy, cmp_rst, done}, 4'b0011);
    chk("result", {gt, eq}, {v.gt, v.eq});
    prev_gt = v.gt;
    prev_eq = v.eq;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h80, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'h80, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, cmp_rst, dvalid, done, gt, eq, x, y}, 10'b0100000000);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_op(vecs[k], 1'b0);
      @(negedge clk);
      chk("done_pulse_end", {done, gt, eq}, {1'b0, prev_gt, prev_eq});
      @(posedge clk);
      #1;
    end

    // back-to-back: second start driven inside the done cycle
    run_op(vecs[0], 1'b0);
    run_op(vecs[3], 1'b0);
    run_op(vecs[1], 1'b0);
    @(posedge clk);
    #1;

    // start during SHIFT with other operands must be ignored
    run_op(vecs[2], 1'b1);
    @(posedge clk);
    #1;

    // reset in the middle of a comparison
    start = 1'b1;
    x_in = 8'hA5;
    y_in = 8'h5A;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midop_reset", {busy, cmp_rst, dvalid, done, gt, eq, x, y}, 10'b0100000000);
    prev_gt = 1'b0;
    prev_eq = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < CC + 4; i++) begin
        @(negedge clk);
        seen += int'(done) + int'(busy);
      end
      chk("no_done_after_reset", 32'(seen), 32'd0);
    end
    @(posedge clk);
    #1;
    run_op(vecs[5], 1'b0);
    run_op(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/compare_digit_driver.md
Name: compare_digit_driver

Overview:
- Transmit-side companion to the serial 2-bit MSB-first comparator (compare_N*_CC*).
- Accepts two N-bit operands in parallel and streams them to the comparator as 2-bit digit pairs, MSB digit first, over CC cycles.
- Drives the comparator's synchronous reset so each comparison starts clean, then captures the comparator's g/e result and returns it with a done pulse.
- Sits between a parallel requester and the comparator core.

Parameters:
N, 16384, operand width in bits; must be even.
CC, 8192, digit cycles per comparison; fixed at N/2 (elaboration error otherwise).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  request a comparison; accepted only when busy=0
x_in  input  N  operand X, sampled on accepted start
y_in  input  N  operand Y, sampled on accepted start
busy  output  1  high from accepted start until done cycle (exclusive)
cmp_rst  output  1  reset to comparator core; high whenever state is IDLE
x  output  2  current X digit to comparator
y  output  2  current Y digit to comparator
dvalid  output  1  high while a digit is presented
g_in  input  1  comparator g output
e_in  input  1  comparator e output
done  output  1  one-cycle pulse: gt/eq updated
gt  output  1  registered result x_in > y_in
eq  output  1  registered result x_in == y_in

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- On rst:
  - state=IDLE, shift registers and digit counter cleared.
  - busy=0, done=0, gt=0, eq=0, dvalid=0, x=y=0, cmp_rst=1.
  - rst mid-operation abandons the comparison; no done pulse.
- States: IDLE, SHIFT, CAPTURE.
- IDLE:
  - cmp_rst=1, dvalid=0, x=y=0, busy=0.
  - On start=1: load xs<=x_in, ys<=y_in, cnt<=0, go to SHIFT.
- SHIFT:
  - cmp_rst=0, dvalid=1, busy=1.
  - x=xs[N-1:N-2], y=ys[N-1:N-2].
  - Each cycle: xs/ys shift left by 2 (zero fill), cnt++.
  - When cnt==CC-1 (last digit presented), go to CAPTURE.
- CAPTURE:
  - cmp_rst=0, dvalid=0, x=y=0, busy=1.
  - Comparator outputs now reflect all CC digits.
  - Register gt<=g_in, eq<=e_in, done<=1 (visible next cycle), go to IDLE.
- done is high for exactly one cycle. That cycle is an IDLE cycle with cmp_rst=1; start is accepted in it (back-to-back operation).
- gt/eq hold their value until the next CAPTURE or rst.
- start while busy=1 is ignored; operands are not resampled.
- Latency, with start accepted at edge t:
  - first digit presented in cycle t+1.
  - last digit in cycle t+CC.
  - CAPTURE in cycle t+CC+1.
  - done/gt/eq valid in cycle t+CC+2.
  - Throughput: one comparison per CC+2 cycles.
- cmp_rst and x/y/dvalid decode from registered state only (glitch-free, no input-to-output combinational path except none).
- cnt width: clog2(CC); no wrap occurs since the exit is at CC-1.
- x_in/y_in may change freely after the accepting edge.
- g_in/e_in are sampled only in CAPTURE and ignored otherwise.

Test Plan (N=8, CC=4, driver connected to comparator model):
- x_in=0xA5, y_in=0x5A, start 1 cycle -> x digits 2,2,1,1 and y digits 1,1,2,2 on cycles t+1..t+4 with dvalid=1; done at t+6 with gt=1, eq=0.
- x_in=y_in=0x3C -> done at t+6, gt=0, eq=1; cmp_rst low exactly cycles t+1..t+5.
- x_in=0x01, y_in=0x80 -> gt=0, eq=0; x digits 0,0,0,1.
- Back-to-back: second start asserted in the done cycle with x_in=0xFF, y_in=0xFE -> second done exactly 6 cycles later, gt=1, eq=0; first result held until then.
- start pulsed during SHIFT with different operands -> ignored; result matches the first operands only.
- rst asserted at t+3 -> next cycle all outputs at reset values (cmp_rst=1, busy=0); no done; a subsequent start runs normally.
